// File: rtl/digit_pkg.sv
// Shared constants, FSM state type and BCD correction helper for the
// digit scan controller and its shift-add-3 conversion engine.
// Ports: none (package).
package digit_pkg;

  localparam int NDIG        = 6;
  localparam int VAL_W       = 17;
  localparam int BCD_W       = 24;
  localparam int CONV_CYCLES = 17;
  localparam int SREG_W      = BCD_W + VAL_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Double-dabble correction: a nibble of 5..9 would become >= 10 after the
  // next shift, so pre-add 3 to make the shift carry into the next digit.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter, one input bit per clock.
// Ports: i_start/i_value (accepted when idle), o_busy, o_bcd (six nibbles),
//        o_done (high in the cycle whose edge performs the final shift).
module bin2bcd_seq
  import digit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [VAL_W-1:0] i_value,
  output logic             o_busy,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_done
);

  logic [SREG_W-1:0] r_sreg;
  logic [4:0]        r_cnt;
  logic              r_busy;
  logic [SREG_W-1:0] w_adj;

  // Correct every BCD nibble before the shift; binary part is untouched.
  always_comb begin
    w_adj = r_sreg;
    for (int i = 0; i < NDIG; i++) begin
      w_adj[VAL_W + 4*i +: 4] = add3(r_sreg[VAL_W + 4*i +: 4]);
    end
  end

  // Combinational so the owner can step its FSM on the same edge as the
  // last shift; o_bcd then holds the final digits in the following cycle.
  assign o_done = r_busy && (r_cnt == 5'(CONV_CYCLES - 1));
  assign o_busy = r_busy;
  assign o_bcd  = r_sreg[SREG_W-1 -: BCD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_sreg <= {w_adj[SREG_W-2:0], 1'b0};
      r_cnt  <= r_cnt + 5'd1;
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end else if (i_start) begin
      r_sreg <= {{BCD_W{1'b0}}, i_value};
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Converts a 17-bit value to six BCD digits and scans them onto one digit
// bus with leading-zero blanking; display is double-buffered.
// Ports: load/value/ready handshake, done pulse, len (significant digits),
//        digit_sel (one-hot), digit_val (BCD), digit_blank.
module digit_scan_ctrl
  import digit_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [VAL_W-1:0] value,
  output logic             ready,
  output logic             done,
  output logic [2:0]       len,
  output logic [5:0]       digit_sel,
  output logic [3:0]       digit_val,
  output logic             digit_blank
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t           r_state;
  logic             r_ready;
  logic             r_done;
  logic [2:0]       r_len;
  logic [BCD_W-1:0] r_dig;
  logic [PRE_W-1:0] r_pre;
  logic [2:0]       r_idx;
  logic [5:0]       r_sel;
  logic [3:0]       r_val;
  logic             r_blank;

  logic             w_start;
  logic             w_eng_busy;
  logic             w_eng_done;
  logic [BCD_W-1:0] w_bcd;
  logic [2:0]       w_len_new;
  logic             w_commit;
  logic             w_wrap;
  logic [2:0]       w_idx_nxt;
  logic [BCD_W-1:0] w_dig_nxt;
  logic [2:0]       w_len_nxt;
  logic [5:0]       w_sel_hot;

  assign w_start  = (r_state == IDLE) && load && !w_eng_busy;
  assign w_commit = (r_state == COMMIT);

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_value (value),
    .o_busy  (w_eng_busy),
    .o_bcd   (w_bcd),
    .o_done  (w_eng_done)
  );

  // Highest nonzero nibble sets the length; zero still shows one digit.
  always_comb begin
    w_len_new = 3'd1;
    for (int i = 1; i < NDIG; i++) begin
      if (w_bcd[4*i +: 4] != 4'd0) begin
        w_len_new = 3'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_len   <= 3'd0;
      r_dig   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= CONV;
            r_ready <= 1'b0;
          end
        end
        CONV: begin
          if (w_eng_done) begin
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          r_dig   <= w_bcd;
          r_len   <= w_len_new;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Scan outputs are computed from the next-cycle digits/len so that a
  // commit and the displayed digit change on the same edge.
  assign w_wrap    = (r_pre == PRE_W'(SCAN_DIV - 1));
  assign w_idx_nxt = w_wrap ? ((r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1) : r_idx;
  assign w_dig_nxt = w_commit ? w_bcd : r_dig;
  assign w_len_nxt = w_commit ? w_len_new : r_len;
  assign w_sel_hot = 6'b000001 << w_idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_idx   <= 3'd0;
      r_sel   <= SEL_ACTIVE_LOW ? 6'b111110 : 6'b000001;
      r_val   <= 4'd0;
      r_blank <= 1'b1;
    end else begin
      r_pre   <= w_wrap ? '0 : r_pre + PRE_W'(1);
      r_idx   <= w_idx_nxt;
      r_sel   <= SEL_ACTIVE_LOW ? ~w_sel_hot : w_sel_hot;
      r_val   <= w_dig_nxt[{w_idx_nxt, 2'b00} +: 4];
      r_blank <= (w_idx_nxt >= w_len_nxt);
    end
  end

  assign ready       = r_ready;
  assign done        = r_done;
  assign len         = r_len;
  assign digit_sel   = r_sel;
  assign digit_val   = r_val;
  assign digit_blank = r_blank;

endmodule
